// File: rtl/branch_resolve_unit.sv
// Branch resolve unit.
// Decides the seven branch/jump conditions from the ALU zero and sign flags and
// registers the PC-source select and redirect target for the IF-stage PC mux.
// A taken branch raises o_flush for FLUSH_CYCLES unstalled cycles, so the
// younger IF/ID and ID/EX contents are discarded. Saturating counters record
// how many conditional branches were taken and how many were not taken.
module branch_resolve_unit #(
    parameter int ADDR_W       = 32,
    parameter int CNT_W        = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_valid,
    input  logic              i_stall,
    input  logic [2:0]        i_branch_type,
    input  logic              i_zero,
    input  logic              i_sign,
    input  logic [ADDR_W-1:0] i_target,
    input  logic              i_clr_stats,
    output logic              o_pc_src,
    output logic [ADDR_W-1:0] o_target,
    output logic              o_flush,
    output logic              o_busy,
    output logic [CNT_W-1:0]  o_taken_cnt,
    output logic [CNT_W-1:0]  o_ntaken_cnt
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

    // Branch type encodings as presented by the decoder.
    localparam logic [2:0] BT_NONE = 3'd0;
    localparam logic [2:0] BT_BEQ  = 3'd1;
    localparam logic [2:0] BT_BNE  = 3'd2;
    localparam logic [2:0] BT_BLEZ = 3'd3;
    localparam logic [2:0] BT_BGTZ = 3'd4;
    localparam logic [2:0] BT_BLTZ = 3'd5;
    localparam logic [2:0] BT_BGEZ = 3'd6;
    localparam logic [2:0] BT_JMP  = 3'd7;

    // The flush countdown must hold FLUSH_CYCLES-1; keep at least one bit.
    localparam int               FCW        = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FCW-1:0]   FLUSH_LOAD = FCW'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_t              state_q, state_d;
    logic [FCW-1:0]      cnt_q, cnt_d;
    logic                pc_src_q, pc_src_d;
    logic [ADDR_W-1:0]   target_q, target_d;
    logic                flush_q, flush_d;
    logic [CNT_W-1:0]    taken_q, taken_d;
    logic [CNT_W-1:0]    ntaken_q, ntaken_d;

    logic cond_true;
    logic accept;
    logic is_cond;

    // Evaluate the branch condition from the ALU flags.
    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        cond_true = 1'b0;
        case (i_branch_type)
            BT_BEQ:  cond_true = i_zero;
            BT_BNE:  cond_true = !i_zero;
            BT_BLEZ: cond_true = i_sign | i_zero;
            BT_BGTZ: cond_true = !i_sign & !i_zero;
            BT_BLTZ: cond_true = i_sign;
            BT_BGEZ: cond_true = !i_sign;
            BT_JMP:  cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

    // Only IDLE samples; a stalled or FLUSH cycle sees nothing (wrong-path work).
    assign accept  = (state_q == S_IDLE) && i_valid && !i_stall && (i_branch_type != BT_NONE);
    assign is_cond = (i_branch_type != BT_NONE) && (i_branch_type != BT_JMP);

    // Next-state, redirect and flush-countdown logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pc_src_d = 1'b0;
        target_d = target_q;
        flush_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept && cond_true) begin
                    pc_src_d = 1'b1;
                    target_d = i_target;
                    flush_d  = 1'b1;
                    // A single-cycle flush needs no countdown state at all.
                    if (FLUSH_CYCLES > 1) begin
                        state_d = S_FLUSH;
                        cnt_d   = FLUSH_LOAD;
                    end
                end
            end
            S_FLUSH: begin
                flush_d = 1'b1;
                if (!i_stall) begin
                    if (cnt_q == '0) begin
                        state_d = S_IDLE;
                        flush_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q - FCW'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Statistics: clear dominates a same-cycle increment; counters stick at max.
    always_comb begin
        taken_d  = taken_q;
        ntaken_d = ntaken_q;
        if (i_clr_stats) begin
            taken_d  = '0;
            ntaken_d = '0;
        end else if (accept && is_cond) begin
            if (cond_true) begin
                if (taken_q != CNT_MAX) taken_d = taken_q + CNT_W'(1);
            end else begin
                if (ntaken_q != CNT_MAX) ntaken_d = ntaken_q + CNT_W'(1);
            end
        end
    end

    // State and output registers; reset clears everything immediately, even mid-flush.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            pc_src_q <= 1'b0;
            target_q <= '0;
            flush_q  <= 1'b0;
            taken_q  <= '0;
            ntaken_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pc_src_q <= pc_src_d;
            target_q <= target_d;
            flush_q  <= flush_d;
            taken_q  <= taken_d;
            ntaken_q <= ntaken_d;
        end
    end

    assign o_pc_src     = pc_src_q;
    assign o_target     = target_q;
    assign o_flush      = flush_q;
    assign o_busy       = (state_q == S_FLUSH);
    assign o_taken_cnt  = taken_q;
    assign o_ntaken_cnt = ntaken_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Testbench for branch_resolve_unit (CNT_W=4 so saturation is reachable).
// Directed vectors push hand-computed expectations into a queue; a monitor on
// the falling edge pops one entry per cycle and compares it to the outputs.
module tb_branch_resolve_unit;

    localparam int ADDR_W = 32;
    localparam int CNT_W  = 4;
    localparam int FLUSH  = 2;

    logic              i_clk = 1'b0;
    logic              i_reset;
    logic              i_valid;
    logic              i_stall;
    logic [2:0]        i_branch_type;
    logic              i_zero;
    logic              i_sign;
    logic [ADDR_W-1:0] i_target;
    logic              i_clr_stats;
    logic              o_pc_src;
    logic [ADDR_W-1:0] o_target;
    logic              o_flush;
    logic              o_busy;
    logic [CNT_W-1:0]  o_taken_cnt;
    logic [CNT_W-1:0]  o_ntaken_cnt;

    branch_resolve_unit #(
        .ADDR_W      (ADDR_W),
        .CNT_W       (CNT_W),
        .FLUSH_CYCLES(FLUSH)
    ) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_valid      (i_valid),
        .i_stall      (i_stall),
        .i_branch_type(i_branch_type),
        .i_zero       (i_zero),
        .i_sign       (i_sign),
        .i_target     (i_target),
        .i_clr_stats  (i_clr_stats),
        .o_pc_src     (o_pc_src),
        .o_target     (o_target),
        .o_flush      (o_flush),
        .o_busy       (o_busy),
        .o_taken_cnt  (o_taken_cnt),
        .o_ntaken_cnt (o_ntaken_cnt)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic              pc;
        logic [ADDR_W-1:0] tgt;
        logic              fl;
        logic              bz;
        logic [CNT_W-1:0]  tk;
        logic [CNT_W-1:0]  ntk;
        int                id;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   vec_id   = 0;

    task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (vector %0d): got 0x%0h, expected 0x%0h", name, id, act, exp);
        end
    endtask

    // Monitor: one expectation per cycle, compared half a period after the edge.
    always @(negedge i_clk) begin : monitor
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("pc_src",     e.id, 32'(o_pc_src),     32'(e.pc));
            check("target",     e.id, o_target,          e.tgt);
            check("flush",      e.id, 32'(o_flush),      32'(e.fl));
            check("busy",       e.id, 32'(o_busy),       32'(e.bz));
            check("taken_cnt",  e.id, 32'(o_taken_cnt),  32'(e.tk));
            check("ntaken_cnt", e.id, 32'(o_ntaken_cnt), 32'(e.ntk));
        end
    end

    // Drive one cycle of inputs and queue the outputs expected after the edge.
    task automatic step(input logic v, input logic st, input logic [2:0] ty,
                        input logic z, input logic s, input logic [31:0] tg, input logic clr,
                        input logic e_pc, input logic [31:0] e_tg, input logic e_fl, input logic e_bz,
                        input logic [3:0] e_tk, input logic [3:0] e_ntk);
        i_valid       = v;
        i_stall       = st;
        i_branch_type = ty;
        i_zero        = z;
        i_sign        = s;
        i_target      = tg;
        i_clr_stats   = clr;
        @(posedge i_clk);
        sb.push_back('{pc: e_pc, tgt: e_tg, fl: e_fl, bz: e_bz, tk: e_tk, ntk: e_ntk, id: vec_id});
        vec_id++;
        #1;
    endtask

    // Valid, unstalled branch.
    task automatic br(input logic [2:0] ty, input logic z, input logic s, input logic [31:0] tg,
                      input logic e_pc, input logic [31:0] e_tg, input logic e_fl, input logic e_bz,
                      input logic [3:0] e_tk, input logic [3:0] e_ntk);
        step(1'b1, 1'b0, ty, z, s, tg, 1'b0, e_pc, e_tg, e_fl, e_bz, e_tk, e_ntk);
    endtask

    // Bubble cycle (no valid instruction), optionally stalled.
    task automatic idle(input logic st, input logic [31:0] e_tg, input logic e_fl, input logic e_bz,
                        input logic [3:0] e_tk, input logic [3:0] e_ntk);
        step(1'b0, st, 3'd0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, e_tg, e_fl, e_bz, e_tk, e_ntk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic [3:0] sat;
        i_reset = 1'b1;
        i_valid = 1'b0; i_stall = 1'b0; i_branch_type = 3'd0;
        i_zero = 1'b0; i_sign = 1'b0; i_target = '0; i_clr_stats = 1'b0;
        repeat (3) @(posedge i_clk);
        sb.push_back('{pc: 1'b0, tgt: 32'h0, fl: 1'b0, bz: 1'b0, tk: 4'd0, ntk: 4'd0, id: vec_id});
        vec_id++;
        #1 i_reset = 1'b0;

        // BEQ taken: redirect to 0x40, flush two cycles.
        br(3'd1, 1, 0, 32'h40,  1, 32'h40, 1, 1, 1, 0);
        idle(0, 32'h40, 1, 1, 1, 0);
        idle(0, 32'h40, 0, 0, 1, 0);
        // BNE with z=1: not taken.
        br(3'd2, 1, 0, 32'h44,  0, 32'h40, 0, 0, 1, 1);
        // BGTZ s=0 z=0: taken to 0x80.
        br(3'd4, 0, 0, 32'h80,  1, 32'h80, 1, 1, 2, 1);
        idle(0, 32'h80, 1, 1, 2, 1);
        idle(0, 32'h80, 0, 0, 2, 1);
        // JMP redirects but is not counted; BEQ during FLUSH is ignored.
        br(3'd7, 0, 0, 32'h100, 1, 32'h100, 1, 1, 2, 1);
        br(3'd1, 1, 0, 32'h200, 0, 32'h100, 1, 1, 2, 1);
        idle(0, 32'h100, 0, 0, 2, 1);
        // BLEZ both polarities.
        br(3'd3, 0, 0, 32'h2f0, 0, 32'h100, 0, 0, 2, 2);
        br(3'd3, 0, 1, 32'h300, 1, 32'h300, 1, 1, 3, 2);
        idle(0, 32'h300, 1, 1, 3, 2);
        idle(0, 32'h300, 0, 0, 3, 2);
        // BGEZ s=1 and BLTZ s=0 fall through.
        br(3'd6, 0, 1, 32'h310, 0, 32'h300, 0, 0, 3, 3);
        br(3'd5, 0, 0, 32'h320, 0, 32'h300, 0, 0, 3, 4);
        // BNE z=0 taken.
        br(3'd2, 0, 0, 32'h340, 1, 32'h340, 1, 1, 4, 4);
        idle(0, 32'h340, 1, 1, 4, 4);
        idle(0, 32'h340, 0, 0, 4, 4);
        // Type NONE with valid is a no-op.
        br(3'd0, 1, 1, 32'h350, 0, 32'h340, 0, 0, 4, 4);
        // Stalled IDLE cycle samples nothing.
        step(1, 1, 3'd1, 1, 0, 32'h360, 0,  0, 32'h340, 0, 0, 4, 4);
        // Taken branch then 3 stalled FLUSH cycles: flush high 5 cycles, pc_src 1 cycle.
        br(3'd1, 1, 0, 32'h400, 1, 32'h400, 1, 1, 5, 4);
        idle(1, 32'h400, 1, 1, 5, 4);
        step(1, 1, 3'd7, 0, 0, 32'h410, 0,  0, 32'h400, 1, 1, 5, 4);
        idle(1, 32'h400, 1, 1, 5, 4);
        idle(0, 32'h400, 1, 1, 5, 4);
        idle(0, 32'h400, 0, 0, 5, 4);
        // BGTZ with z=1 (boundary: zero is not greater than zero).
        br(3'd4, 1, 0, 32'h420, 0, 32'h400, 0, 0, 5, 5);
        // Clear stats, then 17 taken BLTZ saturate taken_cnt at 15.
        step(0, 0, 3'd0, 0, 0, 32'h0, 1,  0, 32'h400, 0, 0, 0, 0);
        for (int i = 1; i <= 17; i++) begin
            sat = (i > 15) ? 4'd15 : 4'(i);
            br(3'd5, 0, 1, 32'h1000 + i, 1, 32'h1000 + i, 1, 1, sat, 0);
            idle(0, 32'h1000 + i, 1, 1, sat, 0);
            idle(0, 32'h1000 + i, 0, 0, sat, 0);
        end
        // Clear in the same cycle as a taken increment: clear wins.
        step(1, 0, 3'd5, 0, 1, 32'h2000, 1,  1, 32'h2000, 1, 1, 0, 0);
        idle(0, 32'h2000, 1, 1, 0, 0);
        idle(0, 32'h2000, 0, 0, 0, 0);

        // Reset asserted in the middle of FLUSH takes effect without a clock edge.
        br(3'd1, 1, 0, 32'h500, 1, 32'h500, 1, 1, 1, 0);
        @(negedge i_clk);
        #1 i_reset = 1'b1;
        #1;
        check("rst_async_pc_src", -1, 32'(o_pc_src),     32'h0);
        check("rst_async_target", -1, o_target,          32'h0);
        check("rst_async_flush",  -1, 32'(o_flush),      32'h0);
        check("rst_async_busy",   -1, 32'(o_busy),       32'h0);
        check("rst_async_taken",  -1, 32'(o_taken_cnt),  32'h0);
        @(posedge i_clk);
        #1 i_reset = 1'b0;
        // After reset, BGEZ s=0 redirects normally.
        br(3'd6, 0, 0, 32'h600, 1, 32'h600, 1, 1, 1, 0);
        idle(0, 32'h600, 1, 1, 1, 0);
        idle(0, 32'h600, 0, 0, 1, 0);

        // Let the monitor drain the queue, bounded.
        for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge i_clk);
        @(negedge i_clk);
        check("scoreboard_drained", -1, 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
